// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_unit
// Description : Forwarding and load-use hazard unit for a 5-stage pipeline.
//               Tracks destination registers through the EX/MEM/WB slots,
//               produces ALU operand forwarding selects, a one-cycle load-use
//               stall, and a saturating stall event counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [CNT_W-1:0]  stall_count
);

    // Comparator slot indices
    localparam int c_NUM_CMP = 6;
    localparam int c_MEM_RS  = 0;
    localparam int c_MEM_RT  = 1;
    localparam int c_WB_RS   = 2;
    localparam int c_WB_RT   = 3;
    localparam int c_EX_IDRS = 4;
    localparam int c_EX_IDRT = 5;

    localparam logic [1:0]       c_SEL_RF  = 2'b00;
    localparam logic [1:0]       c_SEL_MEM = 2'b10;
    localparam logic [1:0]       c_SEL_WB  = 2'b01;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // EX slot
    logic [ADDR_W-1:0] r_ex_rs;
    logic [ADDR_W-1:0] r_ex_rt;
    logic              r_ex_uses_rt;
    logic [ADDR_W-1:0] r_ex_rd;
    logic              r_ex_regwrite;
    logic              r_ex_memread;
    logic              r_ex_valid;
    // MEM slot
    logic [ADDR_W-1:0] r_mem_rd;
    logic              r_mem_regwrite;
    logic              r_mem_valid;
    // WB slot
    logic [ADDR_W-1:0] r_wb_rd;
    logic              r_wb_regwrite;
    logic              r_wb_valid;

    logic [CNT_W-1:0]  r_stall_count;

    // Comparator operands and results
    logic [ADDR_W-1:0]    w_cmp_a [c_NUM_CMP];
    logic [ADDR_W-1:0]    w_cmp_b [c_NUM_CMP];
    logic [c_NUM_CMP-1:0] w_eq;

    logic w_mem_hit_rs;
    logic w_mem_hit_rt;
    logic w_wb_hit_rs;
    logic w_wb_hit_rt;
    logic w_ex_hit_idrs;
    logic w_ex_hit_idrt;
    logic w_stall;

    assign w_cmp_a[c_MEM_RS]  = r_mem_rd;
    assign w_cmp_b[c_MEM_RS]  = r_ex_rs;
    assign w_cmp_a[c_MEM_RT]  = r_mem_rd;
    assign w_cmp_b[c_MEM_RT]  = r_ex_rt;
    assign w_cmp_a[c_WB_RS]   = r_wb_rd;
    assign w_cmp_b[c_WB_RS]   = r_ex_rs;
    assign w_cmp_a[c_WB_RT]   = r_wb_rd;
    assign w_cmp_b[c_WB_RT]   = r_ex_rt;
    assign w_cmp_a[c_EX_IDRS] = r_ex_rd;
    assign w_cmp_b[c_EX_IDRS] = id_rs;
    assign w_cmp_a[c_EX_IDRT] = r_ex_rd;
    assign w_cmp_b[c_EX_IDRT] = id_rt;

    // Bitwise XNOR equality comparators, AND-reduced per comparator
    generate
        for (genvar i = 0; i < c_NUM_CMP; i++) begin : g_cmp
            logic [ADDR_W-1:0] w_bit_eq;
            for (genvar j = 0; j < ADDR_W; j++) begin : g_bit
                assign w_bit_eq[j] = ~(w_cmp_a[i][j] ^ w_cmp_b[i][j]);
            end
            assign w_eq[i] = &w_bit_eq;
        end
    endgenerate

    // A slot "matches" only if it is a live writer of a non-zero register
    assign w_mem_hit_rs  = r_mem_valid & r_mem_regwrite & (|r_mem_rd) & w_eq[c_MEM_RS];
    assign w_mem_hit_rt  = r_mem_valid & r_mem_regwrite & (|r_mem_rd) & w_eq[c_MEM_RT];
    assign w_wb_hit_rs   = r_wb_valid  & r_wb_regwrite  & (|r_wb_rd)  & w_eq[c_WB_RS];
    assign w_wb_hit_rt   = r_wb_valid  & r_wb_regwrite  & (|r_wb_rd)  & w_eq[c_WB_RT];
    assign w_ex_hit_idrs = r_ex_valid  & r_ex_regwrite  & (|r_ex_rd)  & w_eq[c_EX_IDRS];
    assign w_ex_hit_idrt = r_ex_valid  & r_ex_regwrite  & (|r_ex_rd)  & w_eq[c_EX_IDRT];

    // Load-use: the load result is not ready until it leaves MEM
    assign w_stall = id_valid & r_ex_memread &
                     (w_ex_hit_idrs | (id_uses_rt & w_ex_hit_idrt));

    // Forwarding selects; MEM wins over WB since it holds the newer value
    always_comb begin
        fwd_a_sel = c_SEL_RF;
        fwd_b_sel = c_SEL_RF;
        if (w_mem_hit_rs) begin
            fwd_a_sel = c_SEL_MEM;
        end else if (w_wb_hit_rs) begin
            fwd_a_sel = c_SEL_WB;
        end
        if (r_ex_uses_rt) begin
            if (w_mem_hit_rt) begin
                fwd_b_sel = c_SEL_MEM;
            end else if (w_wb_hit_rt) begin
                fwd_b_sel = c_SEL_WB;
            end
        end
    end

    // Slot pipeline advance; a stall injects a bubble into EX
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_rs        <= '0;
            r_ex_rt        <= '0;
            r_ex_uses_rt   <= 1'b0;
            r_ex_rd        <= '0;
            r_ex_regwrite  <= 1'b0;
            r_ex_memread   <= 1'b0;
            r_ex_valid     <= 1'b0;
            r_mem_rd       <= '0;
            r_mem_regwrite <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_regwrite  <= 1'b0;
            r_wb_valid     <= 1'b0;
        end else begin
            r_wb_rd        <= r_mem_rd;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_valid     <= r_mem_valid;
            r_mem_rd       <= r_ex_rd;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_valid    <= r_ex_valid;
            if (w_stall) begin
                r_ex_rs       <= '0;
                r_ex_rt       <= '0;
                r_ex_uses_rt  <= 1'b0;
                r_ex_rd       <= '0;
                r_ex_regwrite <= 1'b0;
                r_ex_memread  <= 1'b0;
                r_ex_valid    <= 1'b0;
            end else begin
                r_ex_rs       <= id_rs;
                r_ex_rt       <= id_rt;
                r_ex_uses_rt  <= id_uses_rt;
                r_ex_rd       <= id_rd;
                r_ex_regwrite <= id_valid & id_regwrite;
                r_ex_memread  <= id_valid & id_memread;
                r_ex_valid    <= id_valid;
            end
        end
    end

    // Saturating count of stall cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != c_CNT_MAX)) begin
            r_stall_count <= r_stall_count + c_CNT_ONE;
        end
    end

    assign stall       = w_stall;
    assign wb_we       = r_wb_valid & r_wb_regwrite & (|r_wb_rd);
    assign wb_addr     = r_wb_rd;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_hazard_unit
// Description : Self-checking bench for fwd_hazard_unit. An instruction-level
//               pipeline model predicts outputs every cycle; directed
//               literal expectations pin the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic              id_uses_rt;
    logic [ADDR_W-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;

    logic [1:0]        fwd_a_sel,  fwd_b_sel;
    logic              stall,      wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [15:0]       stall_count;

    logic [1:0]        fwd_a_sel4, fwd_b_sel4;
    logic              stall4,     wb_we4;
    logic [ADDR_W-1:0] wb_addr4;
    logic [3:0]        stall_count4;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall(stall), .wb_we(wb_we), .wb_addr(wb_addr), .stall_count(stall_count)
    );

    fwd_hazard_unit #(.ADDR_W(ADDR_W), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .fwd_a_sel(fwd_a_sel4), .fwd_b_sel(fwd_b_sel4),
        .stall(stall4), .wb_we(wb_we4), .wb_addr(wb_addr4), .stall_count(stall_count4)
    );

    // ---------------- instruction-level reference model ----------------
    typedef struct {
        bit v; bit rw; bit mr; bit urt;
        int rs; int rt; int rd;
    } ins_t;

    ins_t pipe [3];   // 0 = oldest-to-issue in EX, 1 = MEM, 2 = WB
    int   exp_cnt16;
    int   exp_cnt4;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    function automatic bit writes(ins_t w, int r);
        return w.v && w.rw && (w.rd != 0) && (w.rd == r);
    endfunction

    // Newest in-flight producer of r supplies the operand
    function automatic int src_sel(int r);
        if (writes(pipe[1], r)) return 2;
        if (writes(pipe[2], r)) return 1;
        return 0;
    endfunction

    function automatic bit model_stall();
        return id_valid && pipe[0].mr &&
               (writes(pipe[0], int'(id_rs)) ||
                (id_uses_rt && writes(pipe[0], int'(id_rt))));
    endfunction

    task automatic cmp(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model advance on each clock edge
    always @(posedge clk) begin
        bit s;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
            exp_cnt16 = 0;
            exp_cnt4  = 0;
            chk_en    = 1'b1;
        end else begin
            s = model_stall();
            if (s) begin
                if (exp_cnt16 < 65535) exp_cnt16++;
                if (exp_cnt4 < 15)     exp_cnt4++;
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (s) begin
                pipe[0] = '{default: 0};
            end else begin
                pipe[0].v   = id_valid;
                pipe[0].rw  = id_valid && id_regwrite;
                pipe[0].mr  = id_valid && id_memread;
                pipe[0].urt = id_uses_rt;
                pipe[0].rs  = int'(id_rs);
                pipe[0].rt  = int'(id_rt);
                pipe[0].rd  = int'(id_rd);
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_fwd_a", int'(fwd_a_sel), src_sel(pipe[0].rs));
            cmp("model_fwd_b", int'(fwd_b_sel), pipe[0].urt ? src_sel(pipe[0].rt) : 0);
            cmp("model_stall", int'(stall), int'(model_stall()));
            cmp("model_wb_we", int'(wb_we),
                int'(pipe[2].v && pipe[2].rw && pipe[2].rd != 0));
            cmp("model_wb_addr", int'(wb_addr), pipe[2].rd);
            cmp("model_cnt16", int'(stall_count), exp_cnt16);
            cmp("model_stall4", int'(stall4), int'(model_stall()));
            cmp("model_cnt4", int'(stall_count4), exp_cnt4);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(bit v, int rs, int rt, bit urt, int rd, bit rw, bit mr);
        @(posedge clk);
        #1;
        id_valid    = v;
        id_rs       = ADDR_W'(rs);
        id_rt       = ADDR_W'(rt);
        id_uses_rt  = urt;
        id_rd       = ADDR_W'(rd);
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        id_rd = 0; id_regwrite = 0; id_memread = 0;

        // Reset with random ID activity
        drive(1'($urandom), int'($urandom_range(31)), int'($urandom_range(31)), 1'($urandom),
              int'($urandom_range(31)), 1'($urandom), 1'($urandom));
        drive(1'($urandom), int'($urandom_range(31)), int'($urandom_range(31)), 1'($urandom),
              int'($urandom_range(31)), 1'($urandom), 1'($urandom));
        look();
        cmp("rst_fwd_a", int'(fwd_a_sel), 0);
        cmp("rst_fwd_b", int'(fwd_b_sel), 0);
        cmp("rst_stall", int'(stall), 0);
        cmp("rst_wb_we", int'(wb_we), 0);
        cmp("rst_count", int'(stall_count), 0);
        idle();
        rst_n = 1'b1;
        idle();

        // Back-to-back ALU hazard -> EX/MEM forward
        drive(1, 0, 0, 0, 3, 1, 0);
        drive(1, 3, 0, 0, 0, 0, 0);
        idle();
        look();
        cmp("alu_fwd_a_mem", int'(fwd_a_sel), 2);

        // Producer two slots back -> MEM/WB forward
        drive(1, 0, 0, 0, 3, 1, 0);
        drive(1, 1, 2, 1, 8, 1, 0);
        drive(1, 3, 0, 0, 0, 0, 0);
        idle();
        look();
        cmp("alu_fwd_a_wb", int'(fwd_a_sel), 1);
        cmp("wb_we_writer", int'(wb_we), 1);
        cmp("wb_addr_writer", int'(wb_addr), 3);

        // Two writers of r7, newer one wins
        drive(1, 0, 0, 0, 7, 1, 0);
        drive(1, 0, 0, 0, 7, 1, 0);
        drive(1, 0, 7, 1, 0, 0, 0);
        idle();
        look();
        cmp("dbl_fwd_b_mem", int'(fwd_b_sel), 2);

        // Load-use on rs: one stall cycle, then WB forward
        drive(1, 0, 0, 0, 5, 1, 1);
        drive(1, 5, 0, 0, 0, 0, 0);
        look();
        cmp("lu_stall_on", int'(stall), 1);
        drive(1, 5, 0, 0, 0, 0, 0);
        look();
        cmp("lu_stall_off", int'(stall), 0);
        cmp("lu_count", int'(stall_count), 1);
        idle();
        look();
        cmp("lu_fwd_a_wb", int'(fwd_a_sel), 1);
        idle();
        look();
        cmp("lu_bubble_no_we", int'(wb_we), 0);

        // Register zero never forwards
        drive(1, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        idle();
        look();
        cmp("r0_fwd_a", int'(fwd_a_sel), 0);

        // Load followed by reader that does not use rt
        drive(1, 0, 0, 0, 4, 1, 1);
        drive(1, 0, 4, 0, 0, 0, 0);
        look();
        cmp("nort_stall", int'(stall), 0);
        idle();

        // Reset arriving during a stall
        drive(1, 0, 0, 0, 9, 1, 1);
        drive(1, 9, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        look();
        cmp("mid_stall_pre", int'(stall), 1);
        drive(1, 9, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        look();
        cmp("mid_stall_post", int'(stall), 0);
        cmp("mid_wb_we", int'(wb_we), 0);
        cmp("mid_count", int'(stall_count), 0);
        idle();

        // Saturation of the narrow counter
        for (int k = 0; k < 18; k++) begin
            drive(1, 0, 0, 0, 6, 1, 1);
            drive(1, 6, 0, 0, 0, 0, 0);
            drive(1, 6, 0, 0, 0, 0, 0);
        end
        idle();
        look();
        cmp("sat_count4", int'(stall_count4), 15);
        cmp("sat_count16", int'(stall_count), 18);

        idle();
        idle();
        idle();
        @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Forwarding and load-use hazard unit for the 5-stage datapath.
- Tracks destination-register addresses through the EX, MEM and WB pipeline slots using internal pipeline registers.
- Compares these addresses against source-register addresses with gate-level 5-bit address equality comparators.
- Outputs ALU operand forwarding selects, a one-cycle load-use stall/bubble, and a saturating stall counter for performance debug.

Parameters:
ADDR_W, 5, register-address width; comparators and pipeline address registers are this wide
CNT_W, 16, width of the stall event counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
id_valid  input  1  instruction present in ID this cycle
id_rs  input  ADDR_W  ID source register A address
id_rt  input  ADDR_W  ID source register B address
id_uses_rt  input  1  ID instruction reads rt as a source (0 for immediates and loads)
id_rd  input  ADDR_W  ID destination register address (already muxed rd/rt)
id_regwrite  input  1  ID instruction writes the register file
id_memread  input  1  ID instruction is a load
fwd_a_sel  output  2  EX operand A select: 00 = regfile, 10 = EX/MEM result, 01 = MEM/WB result
fwd_b_sel  output  2  EX operand B select, same encoding as fwd_a_sel
stall  output  1  hold PC and IF/ID; EX receives a bubble next edge
wb_we  output  1  regfile write enable for the WB slot (WB.regwrite and WB.rd != 0)
wb_addr  output  ADDR_W  regfile write address (WB.rd)
stall_count  output  CNT_W  number of stall cycles since reset, saturating

Behaviour:
- Internal slot state:
  - EX slot: rs, rt, uses_rt, rd, regwrite, memread, valid.
  - MEM slot and WB slot: rd, regwrite, valid.
- Reset (rst_n = 0 at an edge):
  - All slot valid, regwrite and memread bits, and all addresses, cleared to 0.
  - stall_count cleared to 0.
  - Outputs after the reset edge: fwd_a_sel = fwd_b_sel = 00, stall = 0, wb_we = 0, wb_addr = 0.
  - A reset asserted mid-operation discards every in-flight slot on that edge. No forwarding or write enable survives it.
- Advance at each rising edge with rst_n = 1:
  - WB slot takes the MEM slot; MEM slot takes the EX slot.
  - If stall = 0, EX slot takes the ID inputs, with valid = id_valid. regwrite and memread are gated by id_valid.
  - If stall = 1, EX slot takes a bubble: valid, regwrite and memread = 0, addresses = 0.
- Match rule: "X matches S" = X.valid and X.regwrite and X.rd != 0 and X.rd == S. Register 0 never matches.
- Forwarding (combinational from slot state, zero latency):
  - fwd_a_sel = 10 if MEM matches EX.rs; else 01 if WB matches EX.rs; else 00.
  - fwd_b_sel follows the same rule against EX.rt, and is forced to 00 when EX.uses_rt = 0.
  - When MEM and WB hold the same rd, MEM has priority because it is the newer value.
- Load-use stall (combinational):
  - stall = id_valid and EX.memread and EX matches id_rs, or id_valid and EX.memread and id_uses_rt and EX matches id_rt.
  - A stall lasts exactly one cycle: the inserted bubble clears EX.memread, so stall deasserts on the next cycle. The load then sits in MEM and is forwarded as 01 one cycle later.
  - The upstream stage must hold the ID inputs stable while stall = 1.
- stall_count:
  - Increments by 1 on each edge where stall = 1.
  - Saturates at 2^CNT_W - 1 and never wraps.
- Writeback:
  - wb_we and wb_addr are driven directly from the WB slot.
  - A same-cycle regfile write and read of one register is the register file's concern (write-before-read). No WB-to-ID forwarding is provided here.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with random ID inputs -> fwd_a_sel = fwd_b_sel = 00, stall = 0, wb_we = 0, stall_count = 0.
- Back-to-back ALU hazard: cycle 0 ID rd = 3, regwrite = 1; cycle 1 ID rs = 3 -> in cycle 2 fwd_a_sel = 10. Then one unrelated instruction with rs = 3 two slots behind gives fwd_a_sel = 01.
- Double hazard priority: two consecutive writers both rd = 7, followed by a reader with rt = 7 and uses_rt = 1 -> fwd_b_sel = 10, not 01.
- Load-use: load rd = 5, memread = 1, followed by reader rs = 5 -> stall = 1 for exactly one cycle and stall_count = 1. The EX bubble has regwrite = 0, and the next cycle gives fwd_a_sel = 01.
- Register zero and no-rt: writer rd = 0 followed by reader rs = 0 -> fwd_a_sel = 00. Load rd = 4 followed by reader with rt = 4 and uses_rt = 0 -> stall = 0.
- Reset mid-flight: load in EX with a matching reader in ID and stall = 1, then pulse rst_n = 0 for one edge -> stall = 0, wb_we = 0, stall_count = 0 after the edge. Separately, force 2^CNT_W stalls with CNT_W = 4 -> stall_count holds at 15.
